// File: rtl/chnl_slave_fifo_if.sv
// Channel-side write port and arbiter-side fetch port of one MCDT channel FIFO.
// Signal suffixes give direction as seen from the FIFO (slave modport).
interface chnl_slave_fifo_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 6
);
  logic [DW-1:0] ch_data_i;
  logic          ch_valid_i;
  logic          ch_ready_o;
  logic [MW-1:0] ch_margin_o;
  logic          a_req_o;
  logic          a_gnt_i;
  logic [DW-1:0] a_data_o;
  logic          a_val_o;

  modport slave (
    input  ch_data_i, ch_valid_i, a_gnt_i,
    output ch_ready_o, ch_margin_o, a_req_o, a_data_o, a_val_o
  );

  modport master (
    output ch_data_i, ch_valid_i, a_gnt_i,
    input  ch_ready_o, ch_margin_o, a_req_o, a_data_o, a_val_o
  );
endinterface

// File: rtl/chnl_slave_fifo.sv
// Channel receive FIFO: buffers initiator writes, advertises free space and
// hands the head word to the MCDT arbiter on a single-cycle grant.
module chnl_slave_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  chnl_slave_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned MW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0] count_q, count_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          a_val_q, a_val_d;

  logic ready_c;
  logic req_c;
  logic push_c;
  logic pop_c;

  // Handshake qualifiers depend only on state and enable, never on valid/grant.
  assign ready_c = rstn_i & en_i & (count_q != MW'(DEPTH));
  assign req_c   = rstn_i & en_i & (count_q != MW'(0));
  assign push_c  = bus.ch_valid_i & ready_c;
  assign pop_c   = bus.a_gnt_i & req_c;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    a_data_d = a_data_q;
    a_val_d  = 1'b0;

    if (push_c) begin
      mem_d[wr_ptr_q] = bus.ch_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    // Head is read from the pre-edge array, so a word written this edge is not visible.
    if (pop_c) begin
      a_data_d = mem_q[rd_ptr_q];
      a_val_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + MW'(1);
      2'b01:   count_d = count_q - MW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_data_q <= '0;
      a_val_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a_data_q <= a_data_d;
      a_val_q  <= a_val_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.ch_ready_o  = ready_c;
  assign bus.ch_margin_o = MW'(DEPTH) - count_q;
  assign bus.a_req_o     = req_c;
  assign bus.a_data_o    = a_data_q;
  assign bus.a_val_o     = a_val_q;
endmodule

// File: tb/tb_chnl_slave_fifo.sv
// Bench for chnl_slave_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the channel FIFO.
module tb_chnl_slave_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned MW    = $clog2(DEPTH) + 1;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  logic en_i   = 1'b0;

  chnl_slave_fifo_if #(.DW(DW), .MW(MW)) bus ();

  chnl_slave_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [DW-1:0] q [$];
  logic          exp_val  = 1'b0;
  logic [DW-1:0] exp_data = '0;
  bit            accepted = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check all outputs mid-cycle, then apply the FIFO rules at the edge.
  task automatic cycle();
    bit e_ready, e_req, push, pop;
    @(negedge clk_i);
    e_ready = rstn_i & en_i & (q.size() != DEPTH);
    e_req   = rstn_i & en_i & (q.size() != 0);
    chk("ready",  64'(bus.ch_ready_o),  64'(e_ready));
    chk("req",    64'(bus.a_req_o),     64'(e_req));
    chk("margin", 64'(bus.ch_margin_o), 64'(DEPTH - q.size()));
    chk("a_val",  64'(bus.a_val_o),     64'(exp_val));
    chk("a_data", 64'(bus.a_data_o),    64'(exp_data));
    push = bus.ch_valid_i & e_ready;
    pop  = bus.a_gnt_i & e_req;
    @(posedge clk_i);
    exp_val = pop;
    if (pop)  exp_data = q.pop_front();
    if (push) q.push_back(bus.ch_data_i);
    accepted = push;
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bus.ch_data_i  = d;
    bus.ch_valid_i = 1'b1;
    accepted       = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) cycle();
    if (!accepted) chk("push_timeout", 64'(0), 64'(1));
    bus.ch_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.a_gnt_i = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) cycle();
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    bus.a_gnt_i = 1'b0;
    cycle();
  endtask

  initial begin
    bus.ch_data_i  = '0;
    bus.ch_valid_i = 1'b0;
    bus.a_gnt_i    = 1'b0;
    en_i           = 1'b1;

    // T1: held in reset, then released with enable high
    cycle();
    cycle();
    rstn_i = 1'b1;
    cycle();
    chk("t1_margin", 64'(bus.ch_margin_o), 64'(32));

    // T2: single word through the FIFO
    push_word(32'h00C0_0000);
    chk("t2_margin", 64'(bus.ch_margin_o), 64'(31));
    bus.a_gnt_i = 1'b1;
    cycle();
    bus.a_gnt_i = 1'b0;
    cycle();
    chk("t2_val_seen", 64'(exp_val), 64'(0));
    cycle();

    // T3: overfill by one, then a single grant frees a slot
    for (int n = 0; n < 32; n++) push_word(32'h00C1_0000 + 32'(n));
    chk("t3_full_margin", 64'(bus.ch_margin_o), 64'(0));
    bus.ch_data_i  = 32'h00C1_0020;
    bus.ch_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold", 64'(accepted), 64'(0));
    end
    bus.a_gnt_i = 1'b1;
    cycle();
    bus.a_gnt_i = 1'b0;
    cycle();
    chk("t3_accept_after_pop", 64'(accepted), 64'(1));
    bus.ch_valid_i = 1'b0;
    drain();

    // T4: steady streaming at count 5
    for (int n = 0; n < 5; n++) push_word(32'h00C2_F000 + 32'(n));
    bus.ch_valid_i = 1'b1;
    bus.a_gnt_i    = 1'b1;
    for (int n = 0; n < 100; n++) begin
      bus.ch_data_i = 32'h00C2_0000 + 32'(n);
      cycle();
      chk("t4_accept", 64'(accepted), 64'(1));
    end
    chk("t4_margin", 64'(bus.ch_margin_o), 64'(27));
    bus.ch_valid_i = 1'b0;
    drain();

    // T5: enable dropped with 8 entries buffered
    for (int n = 0; n < 8; n++) push_word(32'h00C3_0000 + 32'(n));
    en_i           = 1'b0;
    bus.ch_valid_i = 1'b1;
    bus.a_gnt_i    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ch_data_i = $urandom;
      cycle();
    end
    chk("t5_margin", 64'(bus.ch_margin_o), 64'(24));
    en_i           = 1'b1;
    bus.ch_valid_i = 1'b0;
    bus.a_gnt_i    = 1'b0;
    drain();

    // T6: asynchronous reset with 10 entries and a grant in flight
    for (int n = 0; n < 10; n++) push_word(32'h00C4_0000 + 32'(n));
    bus.a_gnt_i = 1'b1;
    cycle();
    bus.a_gnt_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    q.delete();
    exp_val  = 1'b0;
    exp_data = '0;
    chk("t6_val",    64'(bus.a_val_o),     64'(0));
    chk("t6_margin", 64'(bus.ch_margin_o), 64'(32));
    chk("t6_ready",  64'(bus.ch_ready_o),  64'(0));
    chk("t6_req",    64'(bus.a_req_o),     64'(0));
    bus.a_gnt_i    = 1'b1;
    bus.ch_valid_i = 1'b1;
    cycle();
    cycle();
    rstn_i         = 1'b1;
    bus.ch_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    bus.a_gnt_i = 1'b0;

    // Random traffic with occasional enable drops
    for (int i = 0; i < 3000; i++) begin
      en_i           = ($urandom_range(0, 15) != 0);
      bus.ch_valid_i = $urandom_range(0, 1);
      bus.a_gnt_i    = ($urandom_range(0, 2) == 0);
      bus.ch_data_i  = $urandom;
      cycle();
    end
    en_i           = 1'b1;
    bus.ch_valid_i = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
